// File: rtl/sdram_port_arbiter.sv
// Arbitrates the byte-wide SDRAM controller port between the loader (write), cassette and cartridge readers.
// Loader has absolute priority; readers round-robin; a stalled controller is released by a timeout.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK50MHZ,
  input  logic              COCO_RESET_N,
  input  logic              download,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [7:0]        p0_wdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_ack,
  output logic [7:0]        p1_rdata,
  input  logic              p2_req,
  input  logic [ADDR_W-1:0] p2_addr,
  output logic              p2_ack,
  output logic [7:0]        p2_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              timeout_err,
  output logic              busy
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [1:0]        gnt_q;
  logic [1:0]        last_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_din_q;
  logic              mem_rd_q;
  logic              mem_we_q;
  logic              p0_ack_q;
  logic              p1_ack_q;
  logic              p2_ack_q;
  logic [7:0]        p1_rdata_q;
  logic [7:0]        p2_rdata_q;
  logic              timeout_err_q;
  logic              busy_q;

  logic [1:0]        gnt_d;
  logic              any_d;
  logic [ADDR_W-1:0] addr_d;

  // Readers are ineligible while a download runs; a reader tie goes to the port not served last.
  always_comb begin
    gnt_d = 2'd0;
    any_d = 1'b0;
    if (p0_req) begin
      gnt_d = 2'd0;
      any_d = 1'b1;
    end else if (!download && p1_req && p2_req) begin
      gnt_d = (last_q == 2'd2) ? 2'd1 : 2'd2;
      any_d = 1'b1;
    end else if (!download && p1_req) begin
      gnt_d = 2'd1;
      any_d = 1'b1;
    end else if (!download && p2_req) begin
      gnt_d = 2'd2;
      any_d = 1'b1;
    end else begin
      gnt_d = 2'd0;
      any_d = 1'b0;
    end
  end

  always_comb begin
    case (gnt_d)
      2'd0:    addr_d = p0_addr;
      2'd1:    addr_d = p1_addr;
      default: addr_d = p2_addr;
    endcase
  end

  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      state_q       <= S_IDLE;
      gnt_q         <= 2'd0;
      last_q        <= 2'd2;
      cnt_q         <= 8'd0;
      mem_addr_q    <= '0;
      mem_din_q     <= 8'd0;
      mem_rd_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p2_ack_q      <= 1'b0;
      p1_rdata_q    <= 8'd0;
      p2_rdata_q    <= 8'd0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      mem_rd_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p2_ack_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_ready && any_d) begin
            gnt_q      <= gnt_d;
            mem_addr_q <= addr_d;
            mem_din_q  <= p0_wdata;
            mem_we_q   <= (gnt_d == 2'd0);
            mem_rd_q   <= (gnt_d != 2'd0);
            if (gnt_d != 2'd0) begin
              last_q <= gnt_d;
            end
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= 8'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A real ack on the limit cycle beats the timeout.
          if (mem_ack || (cnt_q >= TO_LIMIT)) begin
            timeout_err_q <= !mem_ack;
            state_q       <= S_DONE;
            case (gnt_q)
              2'd0: p0_ack_q <= 1'b1;
              2'd1: begin
                p1_ack_q   <= 1'b1;
                p1_rdata_q <= mem_ack ? mem_dout : 8'hFF;
              end
              default: begin
                p2_ack_q   <= 1'b1;
                p2_rdata_q <= mem_ack ? mem_dout : 8'hFF;
              end
            endcase
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_rd      = mem_rd_q;
  assign mem_we      = mem_we_q;
  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign p2_ack      = p2_ack_q;
  assign p1_rdata    = p1_rdata_q;
  assign p2_rdata    = p2_rdata_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: stimulus queues expected strobes and acks, a monitor pops and compares.
module tb_sdram_port_arbiter;

  localparam int AW = 25;

  logic          CLK50MHZ;
  logic          COCO_RESET_N;
  logic          download;
  logic          p0_req;
  logic [AW-1:0] p0_addr;
  logic [7:0]    p0_wdata;
  logic          p0_ack;
  logic          p1_req;
  logic [AW-1:0] p1_addr;
  logic          p1_ack;
  logic [7:0]    p1_rdata;
  logic          p2_req;
  logic [AW-1:0] p2_addr;
  logic          p2_ack;
  logic [7:0]    p2_rdata;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_rd;
  logic          mem_we;
  logic [7:0]    mem_dout;
  logic          mem_ack;
  logic          timeout_err;
  logic          busy;

  sdram_port_arbiter #(.ADDR_W(AW), .TIMEOUT(16)) dut (
    .CLK50MHZ(CLK50MHZ), .COCO_RESET_N(COCO_RESET_N), .download(download),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .p2_req(p2_req), .p2_addr(p2_addr), .p2_ack(p2_ack), .p2_rdata(p2_rdata),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_dout(mem_dout), .mem_ack(mem_ack),
    .timeout_err(timeout_err), .busy(busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    int            cyc;
  } strb_t;

  typedef struct {
    int         port;
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } ack_t;

  strb_t strb_q[$];
  ack_t  ack_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_strb_cyc = 0;
  int issued[3] = '{0, 0, 0};
  int seen[3] = '{0, 0, 0};
  int resp_delay = 0;
  logic [7:0] resp_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_strb(input logic we, input logic [AW-1:0] addr, input logic [7:0] din, input int c);
    strb_t s;
    s.we = we; s.addr = addr; s.din = din; s.cyc = c;
    strb_q.push_back(s);
  endtask

  task automatic push_ack(input int port, input logic [7:0] rdata, input logic err, input int lat);
    ack_t a;
    a.port = port; a.rdata = rdata; a.err = err; a.lat = lat;
    ack_q.push_back(a);
  endtask

  task automatic step();
    @(posedge CLK50MHZ);
    #1;
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      step();
      if (strb_q.size() == 0 && ack_q.size() == 0 && !busy) done = 1'b1;
    end
    chk({name, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_p0_ack"}, 32'(p0_ack), 32'd0);
    chk({tag, "_p1_ack"}, 32'(p1_ack), 32'd0);
    chk({tag, "_p2_ack"}, 32'(p2_ack), 32'd0);
    chk({tag, "_p1_rdata"}, 32'(p1_rdata), 32'd0);
    chk({tag, "_p2_rdata"}, 32'(p2_rdata), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    CLK50MHZ = 1'b0;
    forever #5 CLK50MHZ = ~CLK50MHZ;
  end

  initial begin
    forever begin
      @(posedge CLK50MHZ);
      cyc = cyc + 1;
    end
  end

  // Registered requesters: hold req while requests are outstanding, drop on ack; reset abandons them.
  initial begin
    p0_req = 1'b0; p1_req = 1'b0; p2_req = 1'b0;
    p0_addr = 25'h100; p0_wdata = 8'hA0;
    forever begin
      @(negedge CLK50MHZ);
      if (!COCO_RESET_N) begin
        for (int i = 0; i < 3; i++) seen[i] = issued[i];
      end else begin
        if (p0_ack) seen[0]++;
        if (p1_ack) seen[1]++;
        if (p2_ack) seen[2]++;
      end
      p0_req   = (issued[0] > seen[0]);
      p1_req   = (issued[1] > seen[1]);
      p2_req   = (issued[2] > seen[2]);
      p0_addr  = 25'h100 + 25'(seen[0]);
      p0_wdata = 8'hA0 + 8'(seen[0]);
    end
  end

  // Controller model: acks resp_delay cycles after a strobe (never when resp_delay is 0).
  initial begin
    int rcnt;
    rcnt = 0;
    mem_ack = 1'b0;
    mem_dout = 8'hEE;
    forever begin
      @(negedge CLK50MHZ);
      mem_ack = 1'b0;
      mem_dout = 8'hEE;
      if (!COCO_RESET_N) begin
        rcnt = 0;
      end else begin
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            mem_ack = 1'b1;
            mem_dout = resp_data;
          end
        end
        if ((mem_rd || mem_we) && resp_delay > 0) rcnt = resp_delay;
      end
    end
  end

  initial begin
    strb_t s;
    ack_t  a;
    int    nacks;
    int    port;
    forever begin
      @(negedge CLK50MHZ);
      if (COCO_RESET_N) begin
        if (mem_rd || mem_we) begin
          chk("rd_we_exclusive", 32'(mem_rd & mem_we), 32'd0);
          chk("strobe_expected", 32'(strb_q.size() != 0), 32'd1);
          if (strb_q.size() != 0) begin
            s = strb_q.pop_front();
            chk("strobe_we", 32'(mem_we), 32'(s.we));
            chk("strobe_addr", 32'(mem_addr), 32'(s.addr));
            if (s.we) chk("strobe_din", 32'(mem_din), 32'(s.din));
            if (s.cyc >= 0) chk("strobe_cycle", 32'(cyc), 32'(s.cyc));
          end
          last_strb_cyc = cyc;
        end
        nacks = int'(p0_ack) + int'(p1_ack) + int'(p2_ack);
        if (nacks != 0 || timeout_err) begin
          chk("ack_onehot", 32'(nacks), 32'd1);
          chk("ack_expected", 32'(ack_q.size() != 0), 32'd1);
          if (ack_q.size() != 0) begin
            a = ack_q.pop_front();
            port = p0_ack ? 0 : (p1_ack ? 1 : (p2_ack ? 2 : 3));
            chk("ack_port", 32'(port), 32'(a.port));
            chk("ack_timeout_err", 32'(timeout_err), 32'(a.err));
            chk("ack_latency", 32'(cyc - last_strb_cyc), 32'(a.lat));
            if (a.port == 1) chk("p1_rdata", 32'(p1_rdata), 32'(a.rdata));
            if (a.port == 2) chk("p2_rdata", 32'(p2_rdata), 32'(a.rdata));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not reach its end, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  rcyc;
    logic done;
    COCO_RESET_N = 1'b1;
    download = 1'b0;
    mem_ready = 1'b1;
    p1_addr = 25'h0;
    p2_addr = 25'h0;
    #2 COCO_RESET_N = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) step();
    COCO_RESET_N = 1'b1;
    step();

    // Single read, controller acks 3 cycles after the strobe.
    resp_delay = 3; resp_data = 8'h5A; p1_addr = 25'h00123;
    push_strb(1'b0, 25'h00123, 8'h00, -1);
    push_ack(1, 8'h5A, 1'b0, 4);
    issued[1]++;
    drain("single_read");

    // Pure timeout on p2 with TIMEOUT=16: ack 18 cycles after ISSUE.
    resp_delay = 0; p2_addr = 25'h00456;
    push_strb(1'b0, 25'h00456, 8'h00, -1);
    push_ack(2, 8'hFF, 1'b1, 18);
    issued[2]++;
    drain("timeout");

    // mem_ack on the exact timeout cycle: real data, no error.
    resp_delay = 17; resp_data = 8'h3C; p1_addr = 25'h00789;
    push_strb(1'b0, 25'h00789, 8'h00, -1);
    push_ack(1, 8'h3C, 1'b0, 18);
    issued[1]++;
    drain("ack_on_limit");

    // mem_ready gating for 50 cycles.
    mem_ready = 1'b0; resp_delay = 2; resp_data = 8'h77; p2_addr = 25'h00ABC;
    issued[2]++;
    repeat (50) step();
    mem_ready = 1'b1;
    rcyc = cyc;
    push_strb(1'b0, 25'h00ABC, 8'h00, rcyc + 1);
    push_ack(2, 8'h77, 1'b0, 3);
    drain("mem_ready");

    // Loader priority during download, then p1 before p2.
    download = 1'b1; resp_delay = 2; resp_data = 8'h99;
    p1_addr = 25'h00011; p2_addr = 25'h00022;
    push_strb(1'b1, 25'h100, 8'hA0, -1);
    push_strb(1'b1, 25'h101, 8'hA1, -1);
    push_strb(1'b1, 25'h102, 8'hA2, -1);
    push_strb(1'b0, 25'h00011, 8'h00, -1);
    push_strb(1'b0, 25'h00022, 8'h00, -1);
    for (int i = 0; i < 3; i++) push_ack(0, 8'h00, 1'b0, 3);
    push_ack(1, 8'h99, 1'b0, 3);
    push_ack(2, 8'h99, 1'b0, 3);
    issued[0] += 3; issued[1]++; issued[2]++;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (seen[0] == 3) done = 1'b1;
    end
    chk("loader_writes_done", 32'(done), 32'd1);
    download = 1'b0;
    drain("loader");

    // Reset during WAIT abandons the transaction.
    resp_delay = 0; p1_addr = 25'h000AB;
    push_strb(1'b0, 25'h000AB, 8'h00, -1);
    issued[1]++;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      if (strb_q.size() == 0) done = 1'b1;
    end
    chk("midwait_strobe_seen", 32'(done), 32'd1);
    repeat (3) step();
    #3 COCO_RESET_N = 1'b0;
    #1 check_all_zero("midwait_reset");
    step();
    step();
    COCO_RESET_N = 1'b1;
    repeat (10) step();
    chk("post_reset_idle", 32'(busy), 32'd0);

    // Round-robin from reset: p1 first, then alternating.
    resp_delay = 1; resp_data = 8'h42;
    p1_addr = 25'h00200; p2_addr = 25'h00300;
    for (int i = 0; i < 2; i++) begin
      push_strb(1'b0, 25'h00200, 8'h00, -1);
      push_strb(1'b0, 25'h00300, 8'h00, -1);
      push_ack(1, 8'h42, 1'b0, 2);
      push_ack(2, 8'h42, 1'b0, 2);
    end
    issued[1] += 2; issued[2] += 2;
    drain("round_robin");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
